// File: rtl/mux_n_way16_pkg.sv
// mux_n_way16_pkg: shared word width and word type for the N-way 16-bit gather mux
package mux_n_way16_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: one-hot grant over req, round-robin from last+1 (lowest index wins with MUX_N_WAY16_FIXED_PRIO_EN)
module rr_arbiter_n
  import mux_n_way16_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SEL_WIDTH = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WAYS-1:0] req,
  input  logic            advance,
  output logic [WAYS-1:0] grant
);
`ifdef MUX_N_WAY16_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk, rst_n, advance};
  assign grant = req & (~req + WAYS'(1));
`else
  logic [SEL_WIDTH-1:0] last_q, last_d;
  always_comb begin
    grant = '0;
    last_d = last_q;
    for (int k = WAYS; k >= 1; k--) begin
      int pos;
      pos = int'(last_q) + k;
      pos = pos >= WAYS ? pos - WAYS : pos;
      if (req[SEL_WIDTH'(pos)]) begin
        grant = '0;
        grant[SEL_WIDTH'(pos)] = 1'b1;
        last_d = advance ? SEL_WIDTH'(pos) : last_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= SEL_WIDTH'(WAYS - 1);
    else last_q <= last_d;
`endif
endmodule

// File: rtl/mux_n_way16_rr.sv
// mux_n_way16_rr: N-way 16-bit valid/ready gather mux with tagged registered output (MUX_N_WAY16_FIXED_PRIO_EN = fixed priority)
module mux_n_way16_rr
  import mux_n_way16_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SEL_WIDTH = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  word_t                in [WAYS],
  input  logic [WAYS-1:0]      in_valid,
  output logic [WAYS-1:0]      in_ready,
  output word_t                out,
  output logic [SEL_WIDTH-1:0] out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [WAYS-1:0] grant;
  logic load, xfer, valid_q, valid_d;
  word_t out_q, out_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  assign load = !valid_q || out_ready;
  assign in_ready = (load && rst_n) ? grant : '0;
  assign xfer = |in_ready;
  rr_arbiter_n #(.WAYS(WAYS), .SEL_WIDTH(SEL_WIDTH)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(in_valid), .advance(xfer), .grant(grant)
  );
  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    for (int i = 0; i < WAYS; i++) begin
      out_d = in_ready[i] ? in[i] : out_d;
      sel_d = in_ready[i] ? SEL_WIDTH'(i) : sel_d;
    end
    valid_d = xfer || (valid_q && !out_ready);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q <= '0;
      sel_q <= '0;
    end else begin
      valid_q <= valid_d;
      out_q <= out_d;
      sel_q <= sel_d;
    end
  assign out = out_q;
  assign out_sel = sel_q;
  assign out_valid = valid_q;
endmodule
